// File: rtl/dataflow_pkg.sv
// Shared constants, helpers and types for the dataflow receive path.
// Contents:
//   DefWidth / DefDepth / DefCntW  default word width, FIFO depth and drop-counter width
//   ptr_w(depth)                   FIFO pointer width; one extra MSB separates full from empty
//   stats_t                        overflow flag plus drop count, at the default counter width
package dataflow_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefCntW  = 8;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic               overflow;
    logic [DefCntW-1:0] drop_count;
  } stats_t;

endpackage

// File: rtl/dataflow_rx_fifo.sv
// First-word-fall-through FIFO for the dataflow receiver.
// Ports:
//   i_clk, i_rst   clock and synchronous active-high reset (pointers only, memory not reset)
//   i_push, i_data write request and word
//   i_pop          read request; ignored while empty
//   o_accept       i_push is being taken this cycle (not full after the same-cycle pop)
//   o_valid        FIFO non-empty, o_data holds the head word
//   o_data         head word, read combinationally from memory
//   o_level        occupancy, 0..Depth
module dataflow_rx_fifo
  import dataflow_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic [Width-1:0]          i_data,
  input  logic                      i_pop,
  output logic                      o_accept,
  output logic                      o_valid,
  output logic [Width-1:0]          o_data,
  output logic [ptr_w(Depth)-1:0]   o_level
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = ptr_w(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same slot, opposite lap: the writer is a full turn ahead of the reader.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so push+pop at full is accepted.
  assign w_accept = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !i_rst) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_accept = w_accept;
  assign o_valid  = ~w_empty;
  assign o_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/dataflow_rx.sv
// Receiving end of the free-running dataflow stream.
// Words arrive one per clock with no backpressure, pass through a capture register, are buffered
// in a FIFO and re-presented on a valid/ready interface. Words that find the FIFO full are
// dropped, flagged (sticky overflow) and counted (saturating drop_count).
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid, in_data     upstream word
//   out_valid, out_ready  downstream handshake; out_data is the FIFO head word
//   level                 FIFO occupancy
//   overflow, drop_count  drop statistics, cleared by clear_stats
module dataflow_rx
  import dataflow_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      clear_stats
);

  // Same shape as dataflow_pkg::stats_t, sized by this instance's CNT_W.
  typedef struct packed {
    logic             overflow;
    logic [CNT_W-1:0] drop_count;
  } stats_w_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             r_cap_valid;
  logic [WIDTH-1:0] r_cap_data;
  stats_w_t         r_stats;
  stats_w_t         w_stats_d;

  logic w_accept;
  logic w_pop;
  logic w_drop;

  // Capture stage: unconditional register of the upstream word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
    end else begin
      r_cap_valid <= in_valid;
      r_cap_data  <= in_data;
    end
  end

  assign w_pop  = out_valid & out_ready;
  assign w_drop = r_cap_valid & ~w_accept;

  dataflow_rx_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_push   (r_cap_valid),
    .i_data   (r_cap_data),
    .i_pop    (w_pop),
    .o_accept (w_accept),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_level  (level)
  );

  // Clear zeroes the count even on a drop cycle, but a drop on that cycle still sets overflow.
  always_comb begin
    w_stats_d = r_stats;
    if (clear_stats) begin
      w_stats_d.drop_count = '0;
      w_stats_d.overflow   = w_drop;
    end else if (w_drop) begin
      w_stats_d.overflow = 1'b1;
      if (r_stats.drop_count != CntMax) begin
        w_stats_d.drop_count = r_stats.drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stats <= '0;
    end else begin
      r_stats <= w_stats_d;
    end
  end

  assign overflow   = r_stats.overflow;
  assign drop_count = r_stats.drop_count;

endmodule

// File: tb/tb_dataflow_rx.sv
module tb_dataflow_rx;

  localparam int Depth  = 16;
  localparam int CntMax = 255;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clear_stats;

  dataflow_rx dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .clear_stats (clear_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of buffered words plus the one-word capture delay.
  logic [7:0] m_q[$];
  logic       m_cap_v;
  logic [7:0] m_cap_d;
  logic       m_ovf;
  int         m_cnt;

  task automatic model_edge(input logic r, input logic iv, input logic [7:0] d,
                            input logic rdy, input logic clr);
    bit drop;
    if (r) begin
      m_q.delete();
      m_cap_v = 1'b0;
      m_ovf   = 1'b0;
      m_cnt   = 0;
      return;
    end
    drop = 1'b0;
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (m_cap_v) begin
      if (m_q.size() < Depth) m_q.push_back(m_cap_d);
      else drop = 1'b1;
    end
    if (clr) begin
      m_cnt = 0;
      m_ovf = drop;
    end else if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < CntMax) m_cnt++;
    end
    m_cap_v = iv;
    m_cap_d = d;
  endtask

  task automatic check_model();
    bit ev;
    bit ok;
    ev = (m_q.size() != 0);
    ok = (out_valid == ev) && (int'(level) == m_q.size()) && (overflow == m_ovf) &&
         (int'(drop_count) == m_cnt) && (!ev || out_data == m_q[0]);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model t=%0t: got valid=%0b data=%02h level=%0d ovf=%0b cnt=%0d, want valid=%0b data=%02h level=%0d ovf=%0b cnt=%0d",
               $time, out_valid, out_data, level, overflow, drop_count,
               ev, ev ? m_q[0] : 8'h00, m_q.size(), m_ovf, m_cnt);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, update model, sample 1ns after the edge.
  task automatic step(input logic r, input logic iv, input logic [7:0] d,
                      input logic rdy, input logic clr);
    rst = r; in_valid = iv; in_data = d; out_ready = rdy; clear_stats = clr;
    @(posedge clk);
    model_edge(r, iv, d, rdy, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    int         el;
  } vec_t;

  vec_t tv[8];

  initial begin
    int n;

    // Basic latency / pop table (expected values written from the handshake rules).
    tv[0] = '{iv: 1'b1, d: 8'hA5, rdy: 1'b1, ev: 1'b0, ed: 8'h00, el: 0};
    tv[1] = '{iv: 1'b0, d: 8'h00, rdy: 1'b1, ev: 1'b1, ed: 8'hA5, el: 1};
    tv[2] = '{iv: 1'b0, d: 8'h00, rdy: 1'b1, ev: 1'b0, ed: 8'h00, el: 0};
    tv[3] = '{iv: 1'b1, d: 8'h3C, rdy: 1'b0, ev: 1'b0, ed: 8'h00, el: 0};
    tv[4] = '{iv: 1'b1, d: 8'h3D, rdy: 1'b0, ev: 1'b1, ed: 8'h3C, el: 1};
    tv[5] = '{iv: 1'b0, d: 8'h00, rdy: 1'b0, ev: 1'b1, ed: 8'h3C, el: 2};
    tv[6] = '{iv: 1'b0, d: 8'h00, rdy: 1'b1, ev: 1'b1, ed: 8'h3D, el: 1};
    tv[7] = '{iv: 1'b0, d: 8'h00, rdy: 1'b1, ev: 1'b0, ed: 8'h00, el: 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_stats = 1'b0;
    m_cap_v = 1'b0; m_cap_d = '0; m_ovf = 1'b0; m_cnt = 0;

    // Reset state.
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", drop_count, 0);

    // 1: table-driven latency and pop.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tv[i].iv, tv[i].d, tv[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), out_valid, tv[i].ev);
      chk($sformatf("tbl%0d_level", i), level, tv[i].el);
      if (tv[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tv[i].ed);
    end

    // 2: fill 16, overflow on 17th, drain in order.
    do_reset();
    for (int k = 0; k <= 16; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    chk("fill_level", level, 16);
    chk("fill_ovf", overflow, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", drop_count, 1);
    for (int k = 0; k < 16; k++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, k);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", out_valid, 0);

    // 3: full with continuous push and pop; pointers wrap.
    do_reset();
    for (int k = 0; k <= 16; k++) step(1'b0, 1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    chk("wrap_fill", level, 16);
    n = 0;
    for (int k = 17; k < 57; k++) begin
      chk("wrap_seq", out_data, 8'h20 + n);
      step(1'b0, 1'b1, 8'(8'h20 + k), 1'b1, 1'b0);
      n++;
      chk("wrap_level", level, 16);
    end
    chk("wrap_cnt", drop_count, 0);

    // 4: saturation, then clear coinciding with a drop.
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    chk("sat_cnt", drop_count, 255);
    chk("sat_ovf", overflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_drop_cnt", drop_count, 0);
    chk("clr_drop_ovf", overflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 0);

    // 5: reset mid-stream.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
    chk("mid_level", level, 5);
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", drop_count, 0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_lat1", out_valid, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_data", out_data, 8'h77);

    // 6: alternating push, random ready.
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      step(1'b0, (c % 2) == 0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      chk("alt_level_bound", int'(level <= 16), 1);
    end
    chk("alt_drop_cnt", drop_count, m_cnt);

    // Fully random traffic including clears and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 99) == 0, 1'($urandom), 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
